display_scan_scheduler: RTL

//   Time-multiplexing controller for the 4-digit seven-segment display path.

---
 rtl/display_pkg.sv | 31 +++
 rtl/scan_timer.sv | 62 ++++++
 rtl/display_scan_scheduler.sv | 75 +++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment display scan path.
// Strobes are active-low, one-cold; nibble positions describe the 16-bit number layout.
package display_pkg;

  localparam logic [3:0] SS_DIG3    = 4'b0111;
  localparam logic [3:0] SS_DIG2    = 4'b1011;
  localparam logic [3:0] SS_DIG1    = 4'b1101;
  localparam logic [3:0] SS_DIG0    = 4'b1110;
  localparam logic [3:0] SS_ALL_OFF = 4'b1111;

  typedef enum logic {
    OWN_LOCAL  = 1'b0,
    OWN_REMOTE = 1'b1
  } owner_t;

  localparam int NIB_W    = 4;
  localparam int NIB0_LSB = 0;
  localparam int NIB1_LSB = 4;
  localparam int NIB2_LSB = 8;
  localparam int NIB3_LSB = 12;

  function automatic logic [3:0] dig_strobe(input logic [1:0] idx);
    case (idx)
      2'd3:    dig_strobe = SS_DIG3;
      2'd2:    dig_strobe = SS_DIG2;
      2'd1:    dig_strobe = SS_DIG1;
      default: dig_strobe = SS_DIG0;
    endcase
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Digit slot timer: walks digits 3..0, blanks the start of each slot and flags
// the last clock of every frame. Outputs are registered from next-state values.
module scan_timer
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [3:0] ss_digit_o,
  output logic       frame_done_o
);

  localparam int                SLOT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);

  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]        dig_idx_q, dig_idx_d;
  logic [3:0]        ss_digit_q, ss_digit_d;
  logic              frame_done_q, frame_done_d;
  logic              blank_d;

  always_comb begin
    slot_cnt_d = slot_cnt_q + SLOT_W'(1);
    dig_idx_d  = dig_idx_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      dig_idx_d  = dig_idx_q - 2'd1;
    end
  end

  // With blanking disabled the compare would be constant, so it is not built at all.
  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign blank_d = 1'b0;
    end else begin : g_blank
      assign blank_d = (slot_cnt_d < SLOT_W'(BLANK_CYCLES));
    end
  endgenerate

  assign ss_digit_d   = blank_d ? SS_ALL_OFF : dig_strobe(dig_idx_d);
  assign frame_done_d = (dig_idx_d == 2'd0) && (slot_cnt_d == SLOT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_cnt_q   <= '0;
      dig_idx_q    <= 2'd3;
      ss_digit_q   <= SS_ALL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      dig_idx_q    <= dig_idx_d;
      ss_digit_q   <= ss_digit_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ss_digit_o   = ss_digit_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: rtl/display_scan_scheduler.sv
// Seven-segment scan scheduler: shares the display between a local and a remote
// requester, arbitrating and snapshotting the shown number only at frame boundaries.
module display_scan_scheduler
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int HOLD_FRAMES  = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        loc_req,
  input  logic [15:0] loc_num,
  input  logic        rem_req,
  input  logic [15:0] rem_num,
  output logic [15:0] disp_num,
  output logic [3:0]  ss_digit,
  output logic        owner,
  output logic        frame_done
);

  localparam int                HOLD_W   = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

  owner_t            owner_q, owner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]       disp_num_q, disp_num_d;
  logic              own_req, other_req;
  logic              boundary;

  scan_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan_timer (
    .clk_i        (clock),
    .rst_ni       (reset_n),
    .ss_digit_o   (ss_digit),
    .frame_done_o (boundary)
  );

  // boundary is high during the last clock of a frame, so the update lands on the frame edge.
  always_comb begin
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    disp_num_d = disp_num_q;
    own_req    = (owner_q == OWN_REMOTE) ? rem_req : loc_req;
    other_req  = (owner_q == OWN_REMOTE) ? loc_req : rem_req;
    if (boundary) begin
      if (other_req && (!own_req || (hold_cnt_q == HOLD_MAX))) begin
        owner_d    = (owner_q == OWN_REMOTE) ? OWN_LOCAL : OWN_REMOTE;
        hold_cnt_d = '0;
      end else if (hold_cnt_q != HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      disp_num_d = (owner_d == OWN_REMOTE) ? rem_num : loc_num;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_q    <= OWN_LOCAL;
      hold_cnt_q <= '0;
      disp_num_q <= '0;
    end else begin
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      disp_num_q <= disp_num_d;
    end
  end

  assign owner      = owner_q;
  assign disp_num   = disp_num_q;
  assign frame_done = boundary;

endmodule
